// File: rtl/inst_mem_loader.sv
// Assembles a received byte stream (MSB first) into instruction words and writes
// them to consecutive word addresses until a halt word is loaded or memory is full.
module inst_mem_loader #(
    parameter int                 INST_SZ   = 32,
    parameter int                 BYTE_SZ   = 8,
    parameter int                 ADDR_SZ   = 32,
    parameter int                 MEM_DEPTH = 64,
    parameter logic [INST_SZ-1:0] HALT_INST = 32'hFFFF_FFFF
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_load_en,
    input  logic                         i_clear,
    input  logic                         i_rx_valid,
    input  logic [BYTE_SZ-1:0]           i_rx_data,
    output logic                         o_write,
    output logic [ADDR_SZ-1:0]           o_addr,
    output logic [INST_SZ-1:0]           o_instruction,
    output logic [$clog2(MEM_DEPTH):0]   o_inst_count,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_error
);

    localparam int                CNT_SZ    = $clog2(MEM_DEPTH) + 1;
    localparam logic [CNT_SZ-1:0] DEPTH_CNT = CNT_SZ'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_SZ-1:0]  addr_reg, addr_next;
    logic [INST_SZ-1:0]  word_reg, word_next;
    logic [1:0]          byte_cnt_reg, byte_cnt_next;
    logic [CNT_SZ-1:0]   count_reg, count_next;
    // Separate output copies so o_addr/o_instruction hold the last written word
    // while the next word is being shifted in.
    logic [ADDR_SZ-1:0]  out_addr_reg, out_addr_next;
    logic [INST_SZ-1:0]  out_inst_reg, out_inst_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            word_reg     <= '0;
            byte_cnt_reg <= '0;
            count_reg    <= '0;
            out_addr_reg <= '0;
            out_inst_reg <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            word_reg     <= word_next;
            byte_cnt_reg <= byte_cnt_next;
            count_reg    <= count_next;
            out_addr_reg <= out_addr_next;
            out_inst_reg <= out_inst_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        word_next     = word_reg;
        byte_cnt_next = byte_cnt_reg;
        count_next    = count_reg;
        out_addr_next = out_addr_reg;
        out_inst_next = out_inst_reg;

        case (state_reg)
            IDLE: begin
                if (i_load_en) begin
                    state_next    = RECV;
                    addr_next     = '0;
                    word_next     = '0;
                    byte_cnt_next = '0;
                    count_next    = '0;
                end
            end
            RECV: begin
                if (i_rx_valid) begin
                    word_next = {word_reg[INST_SZ-BYTE_SZ-1:0], i_rx_data};
                    if (byte_cnt_reg == 2'd3) begin
                        byte_cnt_next = '0;
                        state_next    = WRITE;
                        out_addr_next = addr_reg;
                        out_inst_next = {word_reg[INST_SZ-BYTE_SZ-1:0], i_rx_data};
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                    end
                end
            end
            WRITE: begin
                count_next = count_reg + CNT_SZ'(1);
                if (word_reg == HALT_INST) begin
                    state_next = DONE;
                end else if (count_next == DEPTH_CNT) begin
                    state_next = ERROR;
                end else begin
                    state_next = RECV;
                    addr_next  = addr_reg + ADDR_SZ'(4);
                    // A byte landing during the write cycle starts the next word.
                    if (i_rx_valid) begin
                        word_next     = {{(INST_SZ-BYTE_SZ){1'b0}}, i_rx_data};
                        byte_cnt_next = 2'd1;
                    end
                end
            end
            DONE, ERROR: begin
                if (i_clear) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_write       = (state_reg == WRITE);
    assign o_addr        = out_addr_reg;
    assign o_instruction = out_inst_reg;
    assign o_inst_count  = count_reg;
    assign o_busy        = (state_reg == RECV) || (state_reg == WRITE);
    assign o_done        = (state_reg == DONE);
    assign o_error       = (state_reg == ERROR);

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: a byte-stream level model predicts every
// memory write and the status flags; a forked monitor checks each write strobe.
module tb_inst_mem_loader;

    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic          clear = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          o_write;
    logic [31:0]   o_addr;
    logic [31:0]   o_instruction;
    logic [CW-1:0] o_inst_count;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    inst_mem_loader #(
        .INST_SZ  (32),
        .BYTE_SZ  (8),
        .ADDR_SZ  (32),
        .MEM_DEPTH(DEPTH),
        .HALT_INST(HALT)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_load_en    (load_en),
        .i_clear      (clear),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_write      (o_write),
        .o_addr       (o_addr),
        .o_instruction(o_instruction),
        .o_inst_count (o_inst_count),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [CW-1:0] idx;
    } wr_t;
    wr_t exp_q[$];

    // Model: 0 idle, 1 loading, 2 done, 3 error
    int          mdl_state = 0;
    int          mdl_count = 0;
    int          mdl_nb    = 0;
    logic [31:0] mdl_word  = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void mdl_byte(input logic [7:0] b);
        wr_t w;
        if (mdl_state == 1) begin
            mdl_word = {mdl_word[23:0], b};
            mdl_nb++;
            if (mdl_nb == 4) begin
                w.addr = 32'(mdl_count * 4);
                w.data = mdl_word;
                w.idx  = CW'(mdl_count);
                exp_q.push_back(w);
                mdl_count++;
                mdl_nb = 0;
                if (mdl_word == HALT) mdl_state = 2;
                else if (mdl_count == DEPTH) mdl_state = 3;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        mdl_byte(b);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[31-8*i -: 8]);
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic start_load();
        load_en = 1'b1;
        if (mdl_state == 0) begin
            mdl_state = 1;
            mdl_count = 0;
            mdl_nb    = 0;
            mdl_word  = 32'h0;
        end
        tick();
        load_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        if (mdl_state >= 2) mdl_state = 0;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        repeat (2) tick();
        check({tag, "_done"},  64'(o_done),  64'(mdl_state == 2));
        check({tag, "_error"}, 64'(o_error), 64'(mdl_state == 3));
        check({tag, "_busy"},  64'(o_busy),  64'(mdl_state == 1));
        check({tag, "_count"}, 64'(o_inst_count), 64'(mdl_count));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rst_write"}, 64'(o_write), 64'd0);
        check({tag, "_rst_addr"},  64'(o_addr), 64'd0);
        check({tag, "_rst_inst"},  64'(o_instruction), 64'd0);
        check({tag, "_rst_count"}, 64'(o_inst_count), 64'd0);
        check({tag, "_rst_flags"}, 64'({o_busy, o_done, o_error}), 64'd0);
        mdl_state = 0;
        mdl_count = 0;
        mdl_nb    = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (o_write === 1'b1) begin
                $display("write addr=%08h data=%08h count=%0d", o_addr, o_instruction, o_inst_count);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=%08h data=%08h expected none",
                             o_addr, o_instruction);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr",  64'(o_addr), 64'(e.addr));
                    check("write_data",  64'(o_instruction), 64'(e.data));
                    check("write_count", 64'(o_inst_count), 64'(e.idx));
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        fork
            monitor();
        join_none

        #2;
        do_reset("init");

        // Idle bytes ignored, then basic load ending in halt
        send_byte(8'hAA);
        send_byte(8'h55);
        check_flags("idle");
        start_load();
        send_word(32'h20080005, 0);
        send_word(HALT, 1);
        check_flags("basic");

        // Done ignores bytes and load_en until cleared
        send_word(32'h12345678, 0);
        start_load();
        check_flags("done_hold");
        pulse_clear();
        check_flags("cleared");
        start_load();
        check_flags("restart");

        // Memory full without halt
        for (int i = 1; i <= 4; i++) send_word(32'h11111111 * i, 1);
        check_flags("full");
        send_word(32'hCAFEF00D, 0);
        check_flags("full_hold");
        pulse_clear();

        // Back-to-back bytes, no byte lost during the write cycle
        start_load();
        send_word(32'h00000001, 0);
        send_word(32'h00000002, 0);
        send_word(32'h00000003, 0);
        send_word(HALT, 0);
        check_flags("b2b");
        pulse_clear();

        // Reset in the middle of a word
        start_load();
        send_byte(8'h9A);
        send_byte(8'hBC);
        do_reset("midload");
        start_load();
        send_word(32'hDEADBEEF, 0);
        send_word(HALT, 0);
        check_flags("reload");
        pulse_clear();

        // Randomized loads
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) send_byte(8'($urandom));
            start_load();
            while (mdl_state == 1) begin
                w = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
                send_word(w, $urandom_range(0, 2));
            end
            check_flags("rand");
            repeat ($urandom_range(0, 3)) send_byte(8'($urandom));
            pulse_clear();
            check_flags("rand_clr");
        end

        repeat (4) tick();
        check("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction-memory load port used by the fetch stage.
- Takes a byte stream from the debug UART receiver and assembles 4 bytes into one instruction word, MSB first.
- Writes each word to consecutive word addresses through a one-cycle write strobe, address and data interface.
- Loading stops at a halt instruction or when memory is full, so the fetch stage then reads a fully loaded program from address 0.

Parameters:
INST_SZ, 32, instruction word width (must equal 4*BYTE_SZ)
BYTE_SZ, 8, width of one received byte
ADDR_SZ, 32, width of the byte address driven to instruction memory
MEM_DEPTH, 64, instruction memory capacity in words
HALT_INST, 32'hFFFF_FFFF, word that terminates a load

Ports:
i_clk  in  1  clock; all state changes on rising edge
i_reset  in  1  asynchronous, active-high reset
i_load_en  in  1  start a load (level, sampled in IDLE)
i_clear  in  1  return from DONE/ERROR to IDLE (single-cycle pulse)
i_rx_valid  in  1  i_rx_data valid this cycle (single-cycle pulse per byte)
i_rx_data  in  BYTE_SZ  received byte
o_write  out  1  instruction memory write strobe, exactly one cycle per word
o_addr  out  ADDR_SZ  byte address of the word being written
o_instruction  out  INST_SZ  assembled word
o_inst_count  out  $clog2(MEM_DEPTH)+1  words written in the current load
o_busy  out  1  high in RECV and WRITE
o_done  out  1  high in DONE
o_error  out  1  high in ERROR

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal byte counter 0; word register 0.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - i_rx_valid is ignored.
  - On i_load_en=1: go to RECV; clear address, count, byte counter and word register.
- RECV:
  - On each i_rx_valid: word <= {word[INST_SZ-BYTE_SZ-1:0], i_rx_data}; byte_cnt++.
  - When the 4th byte is accepted: byte_cnt <= 0, next state WRITE.
- WRITE (exactly 1 cycle):
  - o_write=1, o_addr=current address, o_instruction=word.
  - o_inst_count increments by 1 on the clock edge that leaves WRITE.
  - If word==HALT_INST: go to DONE. The halt word is written and counted.
  - Else if the incremented count==MEM_DEPTH: go to ERROR (memory full, no halt seen).
  - Else: address += 4 (wraps modulo 2^ADDR_SZ, unreachable for legal MEM_DEPTH), go to RECV.
  - A byte arriving in WRITE is not lost when the next state is RECV: it becomes byte 0 of the next word (word <= byte, byte_cnt <= 1). It is ignored when the next state is DONE or ERROR.
- Outside WRITE, o_write=0. o_addr and o_instruction hold their last values.
- DONE / ERROR:
  - Flag held high; i_rx_valid and i_load_en are ignored.
  - i_clear=1 -> IDLE. o_inst_count holds until the next load starts.
- i_clear in IDLE, RECV or WRITE: no effect.
- i_load_en dropping mid-load: no effect; the load continues.
- Reset mid-load: partial word discarded. Words already written stay in memory; the loader does not scrub them.
- Latency: o_write is asserted on the cycle after the rising edge that accepted the 4th byte.
- Illegal state encodings return to IDLE.

Test Plan:
1. Reset then load_en. Bytes 20,08,00,05 / FF,FF,FF,FF -> write addr 0 data 0x20080005; write addr 4 data 0xFFFFFFFF; o_done=1, o_inst_count=2, exactly 2 write strobes.
2. MEM_DEPTH=4, feed 4 non-halt words -> writes at addr 0,4,8,12; o_error=1 after 4th write; o_inst_count=4; further bytes produce no writes.
3. Back-to-back bytes with i_rx_valid=1 every cycle, 3 words then halt -> no byte lost; data 0x00000001, 0x00000002, 0x00000003 at addr 0,4,8; halt at 12.
4. Async reset asserted after 2 bytes of word 1 -> outputs 0 immediately, no write. Reload of 1 word + halt writes addr 0 and 4 correctly.
5. DONE, then i_rx_valid pulses and i_load_en=1 without i_clear -> no writes, o_done stays 1. Pulse i_clear -> IDLE; a new load restarts at addr 0 with o_inst_count restarting from 0.
6. i_rx_valid while in IDLE (before load_en) -> ignored; first word after load_en is assembled from post-start bytes only.
